flash_seq_ctrl: RTL and testbench

Programmable flash-pattern sequencer. It drives a single flash output through N on/off pulses with run-time on and off durations. It sequences a dedicated loadable down-counter timer, in the same way the fixed-pattern flasher sequences its timer. It sits between a host/config source (start handshake plus pattern fields) and the lamp/LED output.

---
 rtl/flash_seq_pkg.sv | 15 +
 rtl/flash_seq_timer.sv | 36 +++
 rtl/flash_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_flash_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/flash_seq_pkg.sv
// Shared state encoding and default widths for the programmable flash-pattern sequencer.
package flash_seq_pkg;

    localparam int FS_STATE_W = 2;
    localparam int FS_TW_DEF  = 8;
    localparam int FS_CW_DEF  = 4;

    typedef enum logic [FS_STATE_W-1:0] {
        FS_IDLE = 2'd0,
        FS_ON   = 2'd1,
        FS_OFF  = 2'd2,
        FS_DONE = 2'd3
    } fs_state_t;

endpackage

// File: rtl/flash_seq_timer.sv
// Loadable down-counter; load wins, otherwise counts down and parks at zero.
module flash_seq_timer
    import flash_seq_pkg::*;
#(
    parameter int TW = FS_TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/flash_seq_ctrl.sv
// Flash-pattern sequencer: N ON pulses separated by OFF gaps, durations captured at start.
// Optional FLASH_SEQ_ABORT_EN adds an abort input that ends a running pattern via DONE.
module flash_seq_ctrl
    import flash_seq_pkg::*;
#(
    parameter int TW = FS_TW_DEF,
    parameter int CW = FS_CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] on_len,
    input  logic [TW-1:0] off_len,
    input  logic [CW-1:0] num_flashes,
`ifdef FLASH_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          out,
    output logic          busy,
    output logic          done
);

    fs_state_t     state_q, state_d;
    logic [TW-1:0] on_q, on_d;
    logic [TW-1:0] off_q, off_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    // A zero length behaves as one cycle; the timer holds length-1.
    function automatic logic [TW-1:0] len_m1(input logic [TW-1:0] len);
        return (len == '0) ? '0 : len - TW'(1);
    endfunction

    flash_seq_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        on_d     = on_q;
        off_d    = off_q;
        rem_d    = rem_q;
        tmr_load = 1'b0;
        tmr_val  = len_m1(on_q);

        case (state_q)
            FS_IDLE: begin
                if (start) begin
                    on_d  = on_len;
                    off_d = off_len;
                    if (num_flashes != '0) begin
                        rem_d    = num_flashes - CW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = len_m1(on_len);
                        state_d  = FS_ON;
                    end else begin
                        state_d  = FS_DONE;
                    end
                end
            end
            FS_ON: begin
                if (tmr_zero) begin
                    if (rem_q == '0) begin
                        state_d = FS_DONE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = len_m1(off_q);
                        state_d  = FS_OFF;
                    end
                end
            end
            FS_OFF: begin
                if (tmr_zero) begin
                    rem_d    = rem_q - CW'(1);
                    tmr_load = 1'b1;
                    tmr_val  = len_m1(on_q);
                    state_d  = FS_ON;
                end
            end
            FS_DONE: begin
                state_d = FS_IDLE;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

`ifdef FLASH_SEQ_ABORT_EN
        // Abort only cuts a running pattern short; timer contents are don't-care afterwards.
        if (abort && ((state_q == FS_ON) || (state_q == FS_OFF))) begin
            state_d = FS_DONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            on_q    <= '0;
            off_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
        end
    end

    assign out  = (state_q == FS_ON);
    assign busy = (state_q == FS_ON) || (state_q == FS_OFF);
    assign done = (state_q == FS_DONE);

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// Randomized and directed bench for flash_seq_ctrl against a per-cycle expected-output list.
module tb_flash_seq_ctrl;

    localparam int TW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] on_len;
    logic [TW-1:0] off_len;
    logic [CW-1:0] num_flashes;
    logic          out;
    logic          busy;
    logic          done;
`ifdef FLASH_SEQ_ABORT_EN
    logic          abort;
`endif

    int total = 0;
    int bad   = 0;

    // Expected {out,busy,done} per cycle, starting with the cycle after the accepting edge.
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    flash_seq_ctrl #(
        .TW(TW),
        .CW(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .on_len      (on_len),
        .off_len     (off_len),
        .num_flashes (num_flashes),
`ifdef FLASH_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return 32'({out, busy, done});
    endfunction

    // Pattern from the rules: N ON bursts of L_on, gaps of L_off between them, then one DONE cycle.
    task automatic build(input int lon_raw, input int loff_raw, input int n, input int abort_at);
        int lon;
        int loff;
        lon  = (lon_raw == 0) ? 1 : lon_raw;
        loff = (loff_raw == 0) ? 1 : loff_raw;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < lon; c++) exp_q.push_back(3'b110);
            if (k < n - 1) begin
                for (int c = 0; c < loff; c++) exp_q.push_back(3'b010);
            end
        end
        if (abort_at >= 0 && abort_at < exp_q.size()) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
        end
        exp_q.push_back(3'b001);
    endtask

    task automatic run(input int lon, input int loff, input int n, input bit disturb,
                       input int abort_at, input string tag);
        on_len      = TW'(lon);
        off_len     = TW'(loff);
        num_flashes = CW'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
        build(lon, loff, n, abort_at);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s/cyc%0d", tag, i), obs(), 32'(exp_q[i]));
            if (disturb) begin
                start       = 1'($urandom_range(0, 1));
                on_len      = TW'($urandom);
                off_len     = TW'($urandom);
                num_flashes = CW'($urandom);
            end
`ifdef FLASH_SEQ_ABORT_EN
            abort = (i == abort_at);
`endif
            tick();
        end
        start = 1'b0;
`ifdef FLASH_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        check({tag, "/idle0"}, obs(), 32'h0);
        tick();
        check({tag, "/idle1"}, obs(), 32'h0);
    endtask

    initial begin
        int lon, loff, n, ab, blen;
        rst         = 1'b1;
        start       = 1'b0;
        on_len      = '0;
        off_len     = '0;
        num_flashes = '0;
`ifdef FLASH_SEQ_ABORT_EN
        abort       = 1'b0;
`endif
        tick();
        tick();
        check("reset_outs", obs(), 32'h0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", obs(), 32'h0);

        run(3, 2, 3, 1'b0, -1, "basic");
        run(0, 0, 2, 1'b0, -1, "zero_len");
        run(5, 5, 0, 1'b0, -1, "zero_n");
        run(3, 2, 3, 1'b1, -1, "ignore_start");
        run(255, 1, 1, 1'b0, -1, "max_on");

        // Reset during the second OFF cycle of a 3,2,3 pattern.
        on_len = 8'd3; off_len = 8'd2; num_flashes = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        build(3, 2, 3, -1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_mid/cyc%0d", i), obs(), 32'(exp_q[i]));
            if (i == 4) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_mid/after%0d", i), obs(), 32'h0);
            tick();
        end
        run(2, 3, 2, 1'b0, -1, "after_rst");

`ifdef FLASH_SEQ_ABORT_EN
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_idle%0d", i), obs(), 32'h0);
        end
        abort = 1'b0;
        run(4, 3, 5, 1'b0, 1, "abort_on2");
`endif

        for (int r = 0; r < 40; r++) begin
            lon  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            loff = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            n    = (lon > 20 || loff > 20) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
            ab   = -1;
            blen = (n == 0) ? 0 : n * ((lon == 0) ? 1 : lon) + (n - 1) * ((loff == 0) ? 1 : loff);
`ifdef FLASH_SEQ_ABORT_EN
            if (blen > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, blen - 1));
`endif
            run(lon, loff, n, 1'($urandom_range(0, 1)), ab, $sformatf("rnd%0d_b%0d", r, blen));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick();
                check($sformatf("rnd%0d/gap%0d", r, g), obs(), 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
